// File: rtl/ibex_cheri_memexc_capture.sv
// CHERI memory-exception capture: latches the first faulting LSU access
// and holds its mtval/address until the controller takes the trap.
package ibex_pkg;
  localparam int unsigned CheriExcWidth = 6;
  localparam int unsigned ExcLen    = 0;
  localparam int unsigned ExcTag    = 1;
  localparam int unsigned ExcSeal   = 2;
  localparam int unsigned ExcPermEx = 3;
  localparam int unsigned ExcPermLd = 4;
  localparam int unsigned ExcPermSt = 5;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [5:0]  idx;
  } lsu_req_t;
endpackage

module ibex_cheri_memexc_capture #(
  parameter int unsigned CheriExcWidth = ibex_pkg::CheriExcWidth,
  parameter int unsigned CauseWidth    = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     data_req_i,
  input  logic                     data_gnt_i,
  input  logic                     data_rvalid_i,
  input  logic                     data_first_access_i,
  input  logic [31:0]              data_addr_i,
  input  logic                     data_we_i,
  input  logic [5:0]               auth_idx_i,
  input  logic [CheriExcWidth-1:0] cheri_mem_exc_i,
  input  logic                     exc_ack_i,
  output logic                     exc_valid_o,
  output logic [31:0]              exc_tval_o,
  output logic [31:0]              exc_addr_o,
  output logic                     exc_we_o,
  output logic                     kill_wb_o,
  output logic                     busy_o
);
  import ibex_pkg::*;

  localparam int unsigned PadW = 32 - 6 - CauseWidth;

  localparam logic [CauseWidth-1:0] CauseLen  = CauseWidth'('h01);
  localparam logic [CauseWidth-1:0] CauseTag  = CauseWidth'('h02);
  localparam logic [CauseWidth-1:0] CauseSeal = CauseWidth'('h03);
  localparam logic [CauseWidth-1:0] CausePEx  = CauseWidth'('h11);
  localparam logic [CauseWidth-1:0] CausePLd  = CauseWidth'('h12);
  localparam logic [CauseWidth-1:0] CausePSt  = CauseWidth'('h13);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FAULT
  } state_e;

  state_e   state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic     frp_q, frp_d;
  lsu_req_t req_q;
  logic [31:0] tval_q;
  logic [31:0] addr_q;
  logic     we_q;

  logic gnt;
  logic first_gnt;
  logic sample;
  logic fault_now;
  logic capture;
  logic [CauseWidth-1:0] cause;

  assign gnt       = data_req_i & data_gnt_i;
  assign first_gnt = gnt & data_first_access_i;
  assign sample    = data_rvalid_i & frp_q;
  assign fault_now = sample & (|cheri_mem_exc_i);
  assign capture   = fault_now & (state_q != FAULT);

  always_comb begin
    cause = '0;
    priority case (1'b1)
      cheri_mem_exc_i[ExcTag]:    cause = CauseTag;
      cheri_mem_exc_i[ExcSeal]:   cause = CauseSeal;
      cheri_mem_exc_i[ExcPermEx]: cause = CausePEx;
      cheri_mem_exc_i[ExcPermLd]: cause = CausePLd;
      cheri_mem_exc_i[ExcPermSt]: cause = CausePSt;
      cheri_mem_exc_i[ExcLen]:    cause = CauseLen;
      default:                    cause = '0;
    endcase
  end

  // Saturating outstanding count; simultaneous gnt and rvalid cancel.
  always_comb begin
    cnt_d = cnt_q;
    if (gnt && !data_rvalid_i && cnt_q != 2'd2) begin
      cnt_d = cnt_q + 2'd1;
    end else if (data_rvalid_i && !gnt && cnt_q != 2'd0) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_comb begin
    frp_d = frp_q;
    if (first_gnt) begin
      frp_d = 1'b1;
    end else if (sample) begin
      frp_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (fault_now) begin
          state_d = FAULT;
        end else if (first_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (fault_now) begin
          state_d = FAULT;
        end else if (cnt_d == 2'd0 && !first_gnt) begin
          state_d = IDLE;
        end
      end
      FAULT: begin
        if (exc_ack_i) begin
          state_d = (cnt_d != 2'd0) ? WAIT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      frp_q   <= 1'b0;
      req_q   <= '0;
      tval_q  <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frp_q   <= frp_d;
      if (first_gnt) begin
        req_q <= '{addr: data_addr_i,
                   we:   data_we_i,
                   idx:  auth_idx_i};
      end
      if (capture) begin
        tval_q <= {{PadW{1'b0}}, req_q.idx, cause};
        addr_q <= req_q.addr;
        we_q   <= req_q.we;
      end
    end
  end

  assign exc_valid_o = (state_q == FAULT);
  assign exc_tval_o  = tval_q;
  assign exc_addr_o  = addr_q;
  assign exc_we_o    = we_q;
  assign busy_o      = (cnt_q != 2'd0) | (state_q != IDLE);
  assign kill_wb_o   = rst_ni & data_rvalid_i &
                       (fault_now | (state_q == FAULT));

endmodule

// File: tb/tb_ibex_cheri_memexc_capture.sv
// Directed bench for ibex_cheri_memexc_capture with a
// fault scoreboard popped when exc_valid_o rises.
module tb_ibex_cheri_memexc_capture;

  localparam logic [5:0] V_LEN = 6'b000001;
  localparam logic [5:0] V_TAG = 6'b000010;
  localparam logic [5:0] V_SEAL = 6'b000100;
  localparam logic [5:0] V_PEX = 6'b001000;
  localparam logic [5:0] V_PLD = 6'b010000;
  localparam logic [5:0] V_PST = 6'b100000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic        first = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [5:0]  idx = '0;
  logic [5:0]  vec = '0;
  logic        ack = 1'b0;

  logic        exc_valid;
  logic [31:0] exc_tval;
  logic [31:0] exc_addr;
  logic        exc_we;
  logic        kill_wb;
  logic        busy;

  typedef struct {
    logic [31:0] tval;
    logic [31:0] addr;
    logic        we;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic prev_valid = 1'b0;
  int   nassert = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  ibex_cheri_memexc_capture dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .data_req_i          (req),
    .data_gnt_i          (gnt),
    .data_rvalid_i       (rvalid),
    .data_first_access_i (first),
    .data_addr_i         (addr),
    .data_we_i           (we),
    .auth_idx_i          (idx),
    .cheri_mem_exc_i     (vec),
    .exc_ack_i           (ack),
    .exc_valid_o         (exc_valid),
    .exc_tval_o          (exc_tval),
    .exc_addr_o          (exc_addr),
    .exc_we_o            (exc_we),
    .kill_wb_o           (kill_wb),
    .busy_o              (busy)
  );

  function automatic logic [31:0] exp_tval(
    input logic [5:0] i, input logic [5:0] v);
    logic [4:0] c;
    if (v[1])      c = 5'h02;
    else if (v[2]) c = 5'h03;
    else if (v[3]) c = 5'h11;
    else if (v[4]) c = 5'h12;
    else if (v[5]) c = 5'h13;
    else if (v[0]) c = 5'h01;
    else           c = 5'h00;
    return {21'b0, i, c};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    req = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    first = 1'b0; ack = 1'b0; vec = '0;
    if (exc_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_exc", {31'b0, exc_valid}, 32'd0);
      end else begin
        cur = sb.pop_front();
        chk("sb_tval", exc_tval, cur.tval);
        chk("sb_addr", exc_addr, cur.addr);
        chk("sb_we", {31'b0, exc_we}, {31'b0, cur.we});
      end
    end else if (exc_valid) begin
      chk("hold_tval", exc_tval, cur.tval);
      chk("hold_addr", exc_addr, cur.addr);
    end
    prev_valid = exc_valid;
  endtask

  task automatic grant(input logic f, input logic [31:0] a,
                       input logic w, input logic [5:0] i);
    req = 1'b1; gnt = 1'b1; first = f;
    addr = a; we = w; idx = i;
    tick();
  endtask

  task automatic rsp(input logic [5:0] v, input logic k,
                     input string tag);
    rvalid = 1'b1; vec = v;
    #1;
    chk(tag, {31'b0, kill_wb}, {31'b0, k});
    tick();
  endtask

  task automatic chk_b(input string tag, input logic o,
                       input logic e);
    chk(tag, {31'b0, o}, {31'b0, e});
  endtask

  initial begin
    // Reset with rvalid high: everything quiet
    rvalid = 1'b1;
    #3;
    chk_b("rst_valid", exc_valid, 1'b0);
    chk("rst_tval", exc_tval, 32'd0);
    chk("rst_addr", exc_addr, 32'd0);
    chk_b("rst_we", exc_we, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_kill", kill_wb, 1'b0);
    rvalid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Clean load
    grant(1'b1, 32'h8000_0010, 1'b0, 6'h01);
    chk_b("a_busy1", busy, 1'b1);
    rsp(6'h00, 1'b0, "a_kill");
    chk_b("a_valid", exc_valid, 1'b0);
    chk_b("a_busy0", busy, 1'b0);

    // Stray rvalid at zero must not wrap the counter
    rvalid = 1'b1;
    tick();
    chk_b("under_busy", busy, 1'b0);

    // Three grants saturate at 2; two rvalids drain it
    grant(1'b0, 32'h0, 1'b0, 6'h00);
    grant(1'b0, 32'h0, 1'b0, 6'h00);
    grant(1'b0, 32'h0, 1'b0, 6'h00);
    rsp(6'h00, 1'b0, "sat_kill1");
    chk_b("sat_busy1", busy, 1'b1);
    rsp(6'h00, 1'b0, "sat_kill2");
    chk_b("sat_busy0", busy, 1'b0);

    // Store fault: PERMIT_STORE beats LENGTH
    grant(1'b1, 32'h1000_0004, 1'b1, 6'h05);
    sb.push_back('{tval: 32'h0000_00B3,
                   addr: 32'h1000_0004, we: 1'b1});
    rsp(V_LEN | V_PST, 1'b1, "b_kill");
    chk_b("b_valid", exc_valid, 1'b1);
    tick();
    tick();
    chk_b("b_hold", exc_valid, 1'b1);
    ack = 1'b1;
    tick();
    chk_b("b_ack_valid", exc_valid, 1'b0);
    chk_b("b_ack_busy", busy, 1'b0);

    // TAG beats LENGTH, DDC index
    grant(1'b1, 32'h2000_0000, 1'b0, 6'h21);
    sb.push_back('{tval: 32'h0000_0422,
                   addr: 32'h2000_0000, we: 1'b0});
    rsp(V_TAG | V_LEN, 1'b1, "c_kill");
    chk_b("c_valid", exc_valid, 1'b1);
    ack = 1'b1;
    tick();
    chk_b("c_ack_valid", exc_valid, 1'b0);

    // Split load: second-beat fault vector ignored
    grant(1'b1, 32'h3000_0002, 1'b0, 6'h02);
    grant(1'b0, 32'h3000_0004, 1'b0, 6'h02);
    rsp(6'h00, 1'b0, "d_kill1");
    rsp(V_TAG, 1'b0, "d_kill2");
    chk_b("d_valid", exc_valid, 1'b0);
    chk_b("d_busy", busy, 1'b0);
    tick();
    chk_b("d_valid2", exc_valid, 1'b0);

    // First fault wins over a later faulting access
    grant(1'b1, 32'h4000_0000, 1'b1, 6'h07);
    sb.push_back('{tval: exp_tval(6'h07, V_SEAL),
                   addr: 32'h4000_0000, we: 1'b1});
    rsp(V_SEAL, 1'b1, "e_kill1");
    chk_b("e_valid", exc_valid, 1'b1);
    grant(1'b1, 32'h5000_0000, 1'b0, 6'h02);
    rsp(V_PLD, 1'b1, "e_kill2");
    chk("e_tval_kept", exc_tval, 32'h0000_00E3);
    chk_b("e_busy", busy, 1'b1);
    ack = 1'b1;
    tick();
    chk_b("e_ack_valid", exc_valid, 1'b0);
    chk_b("e_ack_busy", busy, 1'b0);

    // Ack outside FAULT ignored; then reset in FAULT
    grant(1'b1, 32'h6000_0008, 1'b1, 6'h03);
    ack = 1'b1;
    tick();
    chk_b("f_ack_ign", exc_valid, 1'b0);
    chk_b("f_busy", busy, 1'b1);
    grant(1'b0, 32'h6000_000C, 1'b1, 6'h03);
    sb.push_back('{tval: exp_tval(6'h03, V_PEX),
                   addr: 32'h6000_0008, we: 1'b1});
    rsp(V_PEX, 1'b1, "f_kill");
    chk_b("f_valid", exc_valid, 1'b1);
    rvalid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_b("f_rst_valid", exc_valid, 1'b0);
    chk("f_rst_tval", exc_tval, 32'd0);
    chk("f_rst_addr", exc_addr, 32'd0);
    chk_b("f_rst_we", exc_we, 1'b0);
    chk_b("f_rst_busy", busy, 1'b0);
    chk_b("f_rst_kill", kill_wb, 1'b0);
    tick();
    rst_n = 1'b1;
    grant(1'b1, 32'h7000_0000, 1'b0, 6'h00);
    chk_b("g_busy1", busy, 1'b1);
    rsp(6'h00, 1'b0, "g_kill");
    chk_b("g_valid", exc_valid, 1'b0);
    chk_b("g_busy0", busy, 1'b0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nassert, nfail);
    $finish;
  end

endmodule
